// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, access-size encodings
// and the request legality check.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WR     = 3'd3,
    ST_RESP   = 3'd4
  } lsu_state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  // An illegal size, or an address not aligned to the access size, is an error.
  function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return offset[0];
      SIZE_W:  return (offset != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response channel between a requester (master) and the load/store unit (slave).
// Both channels are valid/ready: a transfer happens on the rising edge where valid
// and ready are both 1; the sender holds its payload stable while valid is 1.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extracts and extends a loaded lane, and merges
// store data into a previously read word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_word,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_offset)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

    o_load_data = 32'h0;
    o_merged    = i_word;
    case (i_size)
      SIZE_B: begin
        o_load_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
        case (i_offset)
          2'd0: o_merged[7:0]   = i_wdata[7:0];
          2'd1: o_merged[15:8]  = i_wdata[7:0];
          2'd2: o_merged[23:16] = i_wdata[7:0];
          2'd3: o_merged[31:24] = i_wdata[7:0];
          default: o_merged = i_word;
        endcase
      end
      SIZE_H: begin
        o_load_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
        if (i_offset[1]) o_merged[31:16] = i_wdata;
        else             o_merged[15:0]  = i_wdata;
      end
      SIZE_W:  o_load_data = i_word;
      default: o_load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding request, aligned byte/half/word access to a
// 128-word data memory, sub-word stores done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  load_store_unit_if.slave   req_if,
  output logic [6:0]         o_mem_address,
  output logic [31:0]        o_mem_write_data,
  output logic               o_mem_read,
  output logic               o_mem_write,
  input  logic [31:0]        i_mem_read_data,
  output lsu_state_t         o_dbg_state
);

  lsu_state_t  r_state;
  logic        r_req_ready;
  logic [8:0]  r_addr;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic        r_write;
  logic [31:0] r_mem_wdata;
  logic        r_mem_read;
  logic        r_mem_write;
  logic        r_resp_valid;
  logic [31:0] r_resp_data;
  logic        r_resp_err;

  logic        w_accept;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  assign w_accept = req_if.req_valid && r_req_ready;

  lsu_lane_align u_lane_align (
    .i_size      (r_size),
    .i_unsigned  (r_unsigned),
    .i_offset    (r_addr[1:0]),
    .i_word      (i_mem_read_data),
    .i_wdata     (r_mem_wdata[15:0]),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  // r_mem_wdata doubles as the registered store data until the RMW merge replaces it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_req_ready  <= 1'b1;
      r_addr       <= 9'h0;
      r_size       <= SIZE_B;
      r_unsigned   <= 1'b0;
      r_write      <= 1'b0;
      r_mem_wdata  <= 32'h0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 32'h0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_addr      <= req_if.req_addr;
            r_size      <= req_if.req_size;
            r_unsigned  <= req_if.req_unsigned;
            r_write     <= req_if.req_write;
            r_mem_wdata <= req_if.req_wdata;
            if (is_bad_req(req_if.req_size, req_if.req_addr[1:0])) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_data  <= 32'h0;
              r_state      <= ST_RESP;
            end else if (!req_if.req_write) begin
              r_mem_read <= 1'b1;
              r_state    <= ST_RD;
            end else if (req_if.req_size == SIZE_W) begin
              r_mem_write <= 1'b1;
              r_state     <= ST_WR;
            end else begin
              r_mem_read <= 1'b1;
              r_state    <= ST_RMW_RD;
            end
          end
        end
        ST_RD: begin
          r_mem_read   <= 1'b0;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_data  <= r_write ? 32'h0 : w_load_data;
          r_state      <= ST_RESP;
        end
        ST_RMW_RD: begin
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b1;
          r_mem_wdata <= w_merged;
          r_state     <= ST_WR;
        end
        ST_WR: begin
          r_mem_write  <= 1'b0;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_data  <= 32'h0;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (req_if.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_data  <= 32'h0;
            r_req_ready  <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_mem_read   <= 1'b0;
          r_mem_write  <= 1'b0;
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_if.req_ready  = r_req_ready;
  assign req_if.resp_valid = r_resp_valid;
  assign req_if.resp_data  = r_resp_data;
  assign req_if.resp_err   = r_resp_err;
  assign o_mem_address     = r_addr[8:2];
  assign o_mem_write_data  = r_mem_wdata;
  assign o_mem_read        = r_mem_read;
  assign o_mem_write       = r_mem_write;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 128-word behavioural data memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [6:0]  mem_address;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;
  lsu_state_t  dbg_state;

  logic [31:0] mem [128];
  int          write_count;
  int          access_count;
  logic        overlap_seen;
  logic        idle_access_seen;

  int n_checks;
  int n_errors;

  load_store_unit_if lsu_if ();

  load_store_unit dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .req_if           (lsu_if.slave),
    .o_mem_address    (mem_address),
    .o_mem_write_data (mem_wdata),
    .o_mem_read       (mem_read),
    .o_mem_write      (mem_write),
    .i_mem_read_data  (mem_read_data),
    .o_dbg_state      (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = mem_read ? mem[mem_address] : 32'h0;

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_address] <= mem_wdata;
      write_count      <= write_count + 1;
    end
    if (mem_read || mem_write) access_count <= access_count + 1;
    if (mem_read && mem_write) overlap_seen <= 1'b1;
    if ((dbg_state == ST_IDLE || dbg_state == ST_RESP) && (mem_read || mem_write))
      idle_access_seen <= 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then scramble the request lines.
  task automatic send(input logic wr, input logic [1:0] size, input logic uns,
                      input logic [8:0] addr, input logic [31:0] wdata);
    lsu_if.req_write    = wr;
    lsu_if.req_size     = size;
    lsu_if.req_unsigned = uns;
    lsu_if.req_addr     = addr;
    lsu_if.req_wdata    = wdata;
    lsu_if.req_valid    = 1'b1;
    tick();
    lsu_if.req_valid    = 1'b0;
    lsu_if.req_write    = 1'($urandom_range(0, 1));
    lsu_if.req_size     = 2'($urandom_range(0, 3));
    lsu_if.req_unsigned = 1'($urandom_range(0, 1));
    lsu_if.req_addr     = 9'($urandom_range(0, 511));
    lsu_if.req_wdata    = $urandom;
  endtask

  task automatic take_resp();
    lsu_if.resp_ready = 1'b1;
    tick();
    lsu_if.resp_ready = 1'b0;
  endtask

  int wc0;
  int ac0;

  initial begin
    n_checks = 0;
    n_errors = 0;
    write_count = 0;
    access_count = 0;
    overlap_seen = 1'b0;
    idle_access_seen = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    lsu_if.req_valid = 1'b0;
    lsu_if.req_write = 1'b0;
    lsu_if.req_size = SIZE_B;
    lsu_if.req_unsigned = 1'b0;
    lsu_if.req_addr = 9'h0;
    lsu_if.req_wdata = 32'h0;
    lsu_if.resp_ready = 1'b1;
    rst_n = 1'b0;

    // Reset state, with resp_ready high to show it is ignored outside RESP.
    repeat (2) tick();
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_req_ready", 32'(lsu_if.req_ready), 32'h1);
    check("rst_resp_valid", 32'(lsu_if.resp_valid), 32'h0);
    check("rst_resp_err", 32'(lsu_if.resp_err), 32'h0);
    check("rst_resp_data", lsu_if.resp_data, 32'h0);
    check("rst_mem_rw", {30'h0, mem_read, mem_write}, 32'h0);
    check("rst_mem_addr", 32'(mem_address), 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    #2 rst_n = 1'b1;
    tick();
    lsu_if.resp_ready = 1'b0;

    // Word store 0xDEADBEEF @0x008.
    wc0 = write_count;
    send(1'b1, SIZE_W, 1'b0, 9'h008, 32'hDEADBEEF);
    check("sw_state", 32'(dbg_state), 32'(ST_WR));
    check("sw_mem_write", 32'(mem_write), 32'h1);
    check("sw_mem_read", 32'(mem_read), 32'h0);
    check("sw_mem_addr", 32'(mem_address), 32'h2);
    check("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
    check("sw_req_ready", 32'(lsu_if.req_ready), 32'h0);
    tick();
    check("sw_resp_valid", 32'(lsu_if.resp_valid), 32'h1);
    check("sw_resp_err", 32'(lsu_if.resp_err), 32'h0);
    check("sw_resp_data", lsu_if.resp_data, 32'h0);
    check("sw_write_count", 32'(write_count - wc0), 32'h1);
    check("sw_mem2", mem[2], 32'hDEADBEEF);
    take_resp();
    check("sw_back_idle", 32'(lsu_if.req_ready), 32'h1);

    // Word load @0x008.
    send(1'b0, SIZE_W, 1'b0, 9'h008, 32'h0);
    check("lw_state", 32'(dbg_state), 32'(ST_RD));
    check("lw_mem_read", 32'(mem_read), 32'h1);
    check("lw_mem_addr", 32'(mem_address), 32'h2);
    check("lw_valid_early", 32'(lsu_if.resp_valid), 32'h0);
    tick();
    check("lw_resp_valid", 32'(lsu_if.resp_valid), 32'h1);
    check("lw_resp_data", lsu_if.resp_data, 32'hDEADBEEF);
    check("lw_resp_err", 32'(lsu_if.resp_err), 32'h0);
    take_resp();

    // Signed/unsigned sub-word loads while mem[2] = 0xDEADBEEF.
    send(1'b0, SIZE_B, 1'b0, 9'h00B, 32'h0);
    tick();
    check("lb_signed", lsu_if.resp_data, 32'hFFFFFFDE);
    take_resp();
    send(1'b0, SIZE_B, 1'b1, 9'h00B, 32'h0);
    tick();
    check("lbu", lsu_if.resp_data, 32'h000000DE);
    take_resp();
    send(1'b0, SIZE_H, 1'b0, 9'h00A, 32'h0);
    tick();
    check("lh_signed", lsu_if.resp_data, 32'hFFFFDEAD);
    take_resp();
    send(1'b0, SIZE_H, 1'b0, 9'h008, 32'h0);
    tick();
    check("lh_signed_lo", lsu_if.resp_data, 32'hFFFFBEEF);
    take_resp();

    // Byte store 0x55 @0x009 via read-modify-write.
    wc0 = write_count;
    send(1'b1, SIZE_B, 1'b0, 9'h009, 32'hAAAAAA55);
    check("sb_state_rmw", 32'(dbg_state), 32'(ST_RMW_RD));
    check("sb_rmw_read", {30'h0, mem_read, mem_write}, 32'h2);
    tick();
    check("sb_state_wr", 32'(dbg_state), 32'(ST_WR));
    check("sb_wr_write", {30'h0, mem_read, mem_write}, 32'h1);
    check("sb_wdata", mem_wdata, 32'hDEAD55EF);
    tick();
    check("sb_resp_valid", 32'(lsu_if.resp_valid), 32'h1);
    check("sb_write_count", 32'(write_count - wc0), 32'h1);
    check("sb_mem2", mem[2], 32'hDEAD55EF);
    take_resp();

    // Half store 0x1234 @0x00A, then unsigned byte load of the stored byte.
    send(1'b1, SIZE_H, 1'b0, 9'h00A, 32'hFFFF1234);
    tick();
    check("sh_wdata", mem_wdata, 32'h123455EF);
    tick();
    take_resp();
    check("sh_mem2", mem[2], 32'h123455EF);
    send(1'b0, SIZE_B, 1'b1, 9'h009, 32'h0);
    tick();
    check("lbu_stored", lsu_if.resp_data, 32'h00000055);
    take_resp();

    // Error requests: response right after accept, no memory access.
    ac0 = access_count;
    send(1'b0, SIZE_W, 1'b0, 9'h006, 32'h0);
    check("err_lw_valid", 32'(lsu_if.resp_valid), 32'h1);
    check("err_lw_err", 32'(lsu_if.resp_err), 32'h1);
    check("err_lw_data", lsu_if.resp_data, 32'h0);
    check("err_lw_mem", {30'h0, mem_read, mem_write}, 32'h0);
    take_resp();
    send(1'b1, SIZE_X, 1'b0, 9'h000, 32'h12345678);
    check("err_size_err", 32'(lsu_if.resp_err), 32'h1);
    check("err_size_mem", {30'h0, mem_read, mem_write}, 32'h0);
    take_resp();
    send(1'b0, SIZE_H, 1'b0, 9'h00B, 32'h0);
    check("err_lh_err", 32'(lsu_if.resp_err), 32'h1);
    take_resp();
    check("err_no_access", 32'(access_count - ac0), 32'h0);

    // Back-pressure, with a new request waiting during RESP.
    send(1'b0, SIZE_W, 1'b0, 9'h008, 32'h0);
    tick();
    lsu_if.req_valid = 1'b1;
    lsu_if.req_write = 1'b0;
    lsu_if.req_size = SIZE_W;
    lsu_if.req_unsigned = 1'b0;
    lsu_if.req_addr = 9'h000;
    lsu_if.req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(lsu_if.resp_valid), 32'h1);
      check("bp_data", lsu_if.resp_data, 32'h123455EF);
      check("bp_req_ready", 32'(lsu_if.req_ready), 32'h0);
      tick();
    end
    take_resp();
    check("bp_no_accept_state", 32'(dbg_state), 32'(ST_IDLE));
    check("bp_ready_after", 32'(lsu_if.req_ready), 32'h1);
    tick();
    lsu_if.req_valid = 1'b0;
    check("bp_next_accept", 32'(dbg_state), 32'(ST_RD));
    tick();
    check("bp_next_data", lsu_if.resp_data, 32'h0);
    take_resp();

    // Reset during WR of a byte store.
    wc0 = write_count;
    send(1'b1, SIZE_B, 1'b0, 9'h010, 32'h00000077);
    tick();
    check("rwr_in_wr", 32'(mem_write), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rwr_write_drop", 32'(mem_write), 32'h0);
    check("rwr_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rwr_valid", 32'(lsu_if.resp_valid), 32'h0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("rwr_ready_after", 32'(lsu_if.req_ready), 32'h1);
    check("rwr_no_resp", 32'(lsu_if.resp_valid), 32'h0);
    check("rwr_no_write", 32'(write_count - wc0), 32'h0);
    check("rwr_mem4", mem[4], 32'h0);

    // Unit still works after reset.
    send(1'b0, SIZE_B, 1'b1, 9'h00A, 32'h0);
    tick();
    check("post_rst_lbu", lsu_if.resp_data, 32'h00000034);
    take_resp();

    check("no_rw_overlap", 32'(overlap_seen), 32'h0);
    check("no_idle_access", 32'(idle_access_seen), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have a single clock and a reset that is asynchronous and active-low.
REQ-002 Clk  in  1  clock; all state updates on the rising edge.
REQ-003 Rst_n  in  1  asynchronous active-low reset.
REQ-004 ReqValid  in  1  request present.
REQ-005 ReqReady  out  1  unit can accept a request.
REQ-006 ReqWrite  in  1  1 = store, 0 = load.
REQ-007 ReqSize  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-008 ReqUnsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-009 ReqAddr  in  9  byte address.
REQ-010 ReqWData  in  32  store data, right-aligned.
REQ-011 RespValid  out  1  response present.
REQ-012 RespReady  in  1  consumer takes the response.
REQ-013 RespData  out  32  load result; 0 for stores and errors.
REQ-014 RespErr  out  1  misaligned or illegal-size request.
REQ-015 MemAddress  out  7  word index to DataMemory.
REQ-016 MemWriteData  out  32  word to DataMemory.
REQ-017 MemRead  out  1  DataMemory read enable.
REQ-018 MemWrite  out  1  DataMemory write enable.
REQ-019 MemReadData  in  32  DataMemory read data, combinational from MemAddress while MemRead=1.

Function
REQ-020 SHALL implement FSM states IDLE, RD, RMW_RD, WR, RESP.
REQ-021 SHALL assert ReqReady only in IDLE; a request is accepted on an edge where ReqValid and ReqReady are both 1.
REQ-022 SHALL register ReqAddr, ReqSize, ReqUnsigned, ReqWrite, and ReqWData on acceptance; later input changes SHALL NOT affect the operation.
REQ-023 SHALL drive MemAddress = registered ReqAddr[8:2].
REQ-024 SHALL treat a request as an error and go IDLE->RESP with RespErr=1, with no memory access, when either condition holds: size 11; half with ReqAddr[0]=1; word with ReqAddr[1:0]!=00.
REQ-025 Loads SHALL go IDLE->RD->RESP.
- RD: MemRead=1.
- Selected lane captured into RespData at the RD->RESP edge.
- RespValid is asserted one cycle after the accept edge.
REQ-026 Lane selection is little-endian: byte offset k selects bits [8k+7:8k]; half offset 2 selects bits [31:16].
REQ-027 Sub-word loads SHALL zero-extend or sign-extend per ReqUnsigned; word loads SHALL pass through.
REQ-028 Word stores SHALL go IDLE->WR->RESP: MemWrite=1 for exactly one cycle with MemWriteData=ReqWData.
REQ-029 Sub-word stores SHALL go IDLE->RMW_RD->WR->RESP.
- RMW_RD: MemRead=1; the read word is captured.
- WR: the captured word is written with only the addressed lane(s) replaced by ReqWData[7:0] or ReqWData[15:0].
REQ-030 MemRead and MemWrite SHALL never be 1 simultaneously and SHALL be 0 in IDLE and RESP.
REQ-031 SHALL hold RespValid, RespData, and RespErr stable in RESP until RespReady=1, then return to IDLE.
REQ-032 RespReady SHALL be ignored outside RESP.
REQ-033 SHALL NOT accept a new request in the cycle RESP completes; the earliest next accept is the following edge.
REQ-034 Address wrap is not applicable: the full 9-bit space maps to 128 words.

Reset
REQ-035 While Rst_n=0, SHALL force state=IDLE and ReqReady=1; RespValid, RespErr, MemRead, and MemWrite SHALL be 0; RespData, MemAddress, and MemWriteData SHALL be 0.
REQ-036 Reset asserted mid-operation SHALL abort the operation immediately (asynchronous), including in WR, with no response produced.

Structure
REQ-037 SHALL place the FSM state enumeration and the ReqSize encodings (SIZE_B, SIZE_H, SIZE_W) in a shared package lsu_pkg.
REQ-038 SHALL implement lane extract/extend and lane merge in one combinational sub-module lsu_lane_align, instantiated once.

Verification
REQ-039 Word store, then load: store 0xDEADBEEF @0x008, then load word @0x008. Required: MemWrite one cycle with MemAddress=2; load RespData=0xDEADBEEF, RespErr=0.
REQ-040 Byte store with RMW: mem[2]=0xDEADBEEF, store byte 0x55 @0x009. Required: RMW_RD then WR writes 0xDEAD55EF.
REQ-041 Sign extension: load byte @0x00B with ReqUnsigned=0 -> 0xFFFFFFDE; with ReqUnsigned=1 -> 0x000000DE; load half @0x00A signed -> 0xFFFFDEAD.
REQ-042 Errors: load word @0x006, and a request with size 11. Required: RespErr=1 one cycle after accept, MemRead=MemWrite=0 throughout.
REQ-043 Back-pressure: hold RespReady=0 for 5 cycles after a load. Required: RespValid and RespData stable; ReqReady=0 until the cycle after the handshake.
REQ-044 Reset in WR of a sub-word store: Required: MemWrite drops immediately, no RespValid, ReqReady=1 after release.
